// File: rtl/ps2_kbd_dev_io_if.sv
// ----------------------------------------------------------------------------
// ps2_kbd_dev_io_if
// Bus-side connection between the CPU bus decoder and the PS/2 keyboard
// peripheral.
//   kbd_rd          pop strobe (one cycle)
//   kbd_we          control write strobe (one cycle)
//   kbd_wdata       control word: [31] flush, [30] clr overflow,
//                   [29] clr parity_err, [28] clr frame_err
//   kbd_status_out  {valid, overflow, parity_err, frame_err, 4'b0,
//                    count (zero-extended to 8 bits), 8'b0, head_byte}
//   kbd_ready       FIFO non-empty (interrupt)
// master = bus decoder / CPU side, slave = keyboard peripheral.
// ----------------------------------------------------------------------------
interface ps2_kbd_dev_io_if;
    logic        kbd_rd;
    logic        kbd_we;
    logic [31:0] kbd_wdata;
    logic [31:0] kbd_status_out;
    logic        kbd_ready;

    modport master (
        output kbd_rd,
        output kbd_we,
        output kbd_wdata,
        input  kbd_status_out,
        input  kbd_ready
    );

    modport slave (
        input  kbd_rd,
        input  kbd_we,
        input  kbd_wdata,
        output kbd_status_out,
        output kbd_ready
    );
endinterface

// File: rtl/ps2_kbd_dev_io.sv
// ----------------------------------------------------------------------------
// ps2_kbd_dev_io
// PS/2 keyboard receiver exposed as a polled / interrupting bus peripheral.
// Deserialises 11-bit device-to-host frames, checks start/parity/stop and
// queues good bytes in a small FIFO.
// Ports:
//   clk       system clock (all logic on this clock)
//   rst       synchronous active-high reset
//   ps2_clk   asynchronous PS/2 clock from the keyboard
//   ps2_data  asynchronous PS/2 data from the keyboard
//   bus       slave side of ps2_kbd_dev_io_if (rd/we/wdata in, status/ready out)
// ----------------------------------------------------------------------------
module ps2_kbd_dev_io #(
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    ps2_kbd_dev_io_if.slave      bus
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned FCW   = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and ps2_clk glitch filter
    // ------------------------------------------------------------------
    logic           r_clk_s1, r_clk_s2;
    logic           r_dat_s1, r_dat_s2;
    logic           r_filt;
    logic [FCW-1:0] r_fcnt;
    logic           w_filt_flip;
    logic           w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock follows the synchronised one only after FILTER_LEN
    // consecutive samples disagree with it; any agreeing sample restarts the run.
    assign w_filt_flip = (r_clk_s2 != r_filt) && (r_fcnt == FCW'(FILTER_LEN - 1));
    assign w_fall      = w_filt_flip && r_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_fcnt <= '0;
        end else if (w_filt_flip) begin
            r_filt <= r_clk_s2;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t         r_state, w_state_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic [2:0]     r_bitcnt, w_bitcnt_nxt;
    logic           r_par_ok, w_par_ok_nxt;
    logic [TCW-1:0] r_tmo;
    logic           w_timeout;
    logic           w_push;
    logic           w_set_ferr;
    logic           w_set_perr;

    assign w_timeout = (r_state != StIdle) && (r_tmo == TCW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_par_ok_nxt = r_par_ok;
        w_push       = 1'b0;
        w_set_ferr   = 1'b0;
        w_set_perr   = 1'b0;
        if (w_timeout) begin
            // Keyboard stalled mid-frame: drop the partial byte.
            w_state_nxt = StIdle;
            w_shift_nxt = '0;
            w_set_ferr  = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_dat_s2) begin
                        w_state_nxt  = StData;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_set_ferr = 1'b1;
                    end
                end
                StData: begin
                    // LSB first on the wire: shift right, new bit at the top.
                    w_shift_nxt  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = StParity;
                    end
                end
                StParity: begin
                    w_par_ok_nxt = ^{r_shift, r_dat_s2};
                    w_state_nxt  = StStop;
                end
                StStop: begin
                    w_push      = r_dat_s2 && r_par_ok;
                    w_set_ferr  = !r_dat_s2;
                    w_set_perr  = !r_par_ok;
                    w_state_nxt = StIdle;
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_par_ok <= w_par_ok_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == StIdle || w_fall || w_timeout) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0]      r_count;
    logic               w_empty, w_full;
    logic               w_pop_ok, w_push_ok;
    logic               w_flush;
    logic               w_set_ovf;
    logic [7:0]         w_head;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_flush   = bus.kbd_we && bus.kbd_wdata[31];
    assign w_pop_ok  = bus.kbd_rd && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok = w_push && (!w_full || w_pop_ok) && !w_flush;
    assign w_set_ovf = w_push && w_full && !w_pop_ok;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set in the same cycle as a clear wins
    // ------------------------------------------------------------------
    logic r_ovf, r_perr, r_ferr;
    logic w_clr_ovf, w_clr_perr, w_clr_ferr;

    assign w_clr_ovf  = bus.kbd_we && bus.kbd_wdata[30];
    assign w_clr_perr = bus.kbd_we && bus.kbd_wdata[29];
    assign w_clr_ferr = bus.kbd_we && bus.kbd_wdata[28];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovf  <= w_set_ovf  || (r_ovf  && !w_clr_ovf);
            r_perr <= w_set_perr || (r_perr && !w_clr_perr);
            r_ferr <= w_set_ferr || (r_ferr && !w_clr_ferr);
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    logic w_unused_wdata;

    assign w_unused_wdata = ^bus.kbd_wdata[27:0];
    assign w_head         = w_empty ? 8'h00 : r_mem[r_rptr];

    assign bus.kbd_status_out = {!w_empty, r_ovf, r_perr, r_ferr, 4'b0000,
                                 8'(r_count), 8'h00, w_head};
    assign bus.kbd_ready      = !w_empty;

endmodule

// File: tb/tb_ps2_kbd_dev_io.sv
// ----------------------------------------------------------------------------
// tb_ps2_kbd_dev_io
// Self-checking bench for ps2_kbd_dev_io. Drives PS/2 frames bit by bit
// (40 clk bit period), keeps a scoreboard queue of expected FIFO bytes plus
// model flags, and compares the status word / ready against them.
// ----------------------------------------------------------------------------
module tb_ps2_kbd_dev_io;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    always #5 clk = ~clk;

    ps2_kbd_dev_io_if bus_if ();

    ps2_kbd_dev_io #(
        .FIFO_AW        (3),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];
    bit m_ovf, m_perr, m_ferr;

    function automatic logic [31:0] model_status();
        logic [7:0] h;
        h = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        return {exp_q.size() != 0, m_ovf, m_perr, m_ferr, 4'b0000,
                8'(exp_q.size()), 8'h00, h};
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, falling edge mid-period.
    task automatic ps2_bit(input logic b, input bit rd_on_fall);
        ps2_data = b;
        tick(10);
        ps2_clk = 1'b0;
        if (rd_on_fall) begin
            // Lines the pop strobe up with the cycle the filtered fall lands.
            tick(5);
            bus_if.kbd_rd = 1'b1;
            tick(1);
            bus_if.kbd_rd = 1'b0;
            tick(14);
        end else begin
            tick(20);
        end
        ps2_clk = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop,
                              input bit rd_on_stop);
        logic par;
        par = (~^b) ^ flip_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, rd_on_stop);
        ps2_data = 1'b1;
        if (rd_on_stop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (stop && !flip_par) begin
            if (exp_q.size() == 8) m_ovf = 1'b1;
            else exp_q.push_back(b);
        end
        if (!stop) m_ferr = 1'b1;
        if (flip_par) m_perr = 1'b1;
        tick(5);
    endtask

    task automatic pop_byte();
        bus_if.kbd_rd = 1'b1;
        tick(1);
        bus_if.kbd_rd = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick(1);
    endtask

    task automatic write_ctrl(input logic [31:0] w);
        bus_if.kbd_wdata = w;
        bus_if.kbd_we    = 1'b1;
        tick(1);
        bus_if.kbd_we    = 1'b0;
        bus_if.kbd_wdata = '0;
        if (w[31]) exp_q.delete();
        if (w[30]) m_ovf  = 1'b0;
        if (w[29]) m_perr = 1'b0;
        if (w[28]) m_ferr = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_clear();
        tick(1);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL reset_status got %h want %h", bus_if.kbd_status_out, 32'h0);
        end
        n_vec++;
        if (bus_if.kbd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready got %b want 0", bus_if.kbd_ready);
        end
    endtask

    task automatic test_good_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h8001_001C) begin
            n_err++;
            $display("FAIL good_status got %h want %h", bus_if.kbd_status_out, 32'h8001_001C);
        end
        n_vec++;
        if (bus_if.kbd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL good_ready got %b want 1", bus_if.kbd_ready);
        end
        pop_byte();
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL good_pop got %h want %h", bus_if.kbd_status_out, 32'h0);
        end
    endtask

    task automatic test_bad_parity();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL parity_status got %h want %h", bus_if.kbd_status_out, 32'h2000_0000);
        end
        write_ctrl(32'h2000_0000);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL parity_clear got %h want %h", bus_if.kbd_status_out, 32'h0);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] want;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'hC008_0001) begin
            n_err++;
            $display("FAIL ovf_status got %h want %h", bus_if.kbd_status_out, 32'hC008_0001);
        end
        for (int i = 0; i < 8; i++) begin
            want = exp_q[0];
            n_vec++;
            if (bus_if.kbd_status_out[7:0] !== want || bus_if.kbd_ready !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_read%0d got %h ready %b want %h ready 1", i,
                         bus_if.kbd_status_out[7:0], bus_if.kbd_ready, want);
            end
            pop_byte();
        end
        pop_byte();
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h4000_0000) begin
            n_err++;
            $display("FAIL ovf_empty_pop got %h want %h", bus_if.kbd_status_out, 32'h4000_0000);
        end
        write_ctrl(32'h4000_0000);
        n_vec++;
        if (bus_if.kbd_status_out !== model_status()) begin
            n_err++;
            $display("FAIL ovf_clear got %h want %h", bus_if.kbd_status_out, model_status());
        end
    endtask

    task automatic test_timeout();
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        tick(230);
        m_ferr = 1'b1;
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h1000_0000) begin
            n_err++;
            $display("FAIL timeout_ferr got %h want %h", bus_if.kbd_status_out, 32'h1000_0000);
        end
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h9001_00F0) begin
            n_err++;
            $display("FAIL timeout_next got %h want %h", bus_if.kbd_status_out, 32'h9001_00F0);
        end
        pop_byte();
        write_ctrl(32'h1000_0000);
        n_vec++;
        if (bus_if.kbd_status_out !== model_status()) begin
            n_err++;
            $display("FAIL timeout_clear got %h want %h", bus_if.kbd_status_out, model_status());
        end
    endtask

    task automatic test_glitch();
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        tick(2);
        ps2_clk  = 1'b1;
        tick(20);
        n_vec++;
        if (bus_if.kbd_status_out !== model_status()) begin
            n_err++;
            $display("FAIL glitch_status got %h want %h", bus_if.kbd_status_out, model_status());
        end
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h8001_0033) begin
            n_err++;
            $display("FAIL glitch_next got %h want %h", bus_if.kbd_status_out, 32'h8001_0033);
        end
        pop_byte();
    endtask

    task automatic test_simultaneous();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h8001_005A) begin
            n_err++;
            $display("FAIL simul_pushpop got %h want %h", bus_if.kbd_status_out, 32'h8001_005A);
        end
        pop_byte();
        // Reset in the middle of a frame
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        ps2_data = 1'b1;
        model_clear();
        tick(1);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h0000_0000 || bus_if.kbd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_rst got %h ready %b want 00000000 ready 0",
                     bus_if.kbd_status_out, bus_if.kbd_ready);
        end
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h8001_00A5) begin
            n_err++;
            $display("FAIL midframe_next got %h want %h", bus_if.kbd_status_out, 32'h8001_00A5);
        end
        pop_byte();
    endtask

    task automatic test_flush_and_bad_stop();
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        send_frame(8'h42, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h9001_0021) begin
            n_err++;
            $display("FAIL bad_stop got %h want %h", bus_if.kbd_status_out, 32'h9001_0021);
        end
        write_ctrl(32'h9000_0000);
        n_vec++;
        if (bus_if.kbd_status_out !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL flush got %h want %h", bus_if.kbd_status_out, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] want;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b0, 1'b1, 1'b0);
        end
        n_vec++;
        if (bus_if.kbd_status_out !== model_status()) begin
            n_err++;
            $display("FAIL b2b_status got %h want %h", bus_if.kbd_status_out, model_status());
        end
        while (exp_q.size() != 0) begin
            want = exp_q[0];
            n_vec++;
            if (bus_if.kbd_status_out[7:0] !== want) begin
                n_err++;
                $display("FAIL b2b_byte got %h want %h", bus_if.kbd_status_out[7:0], want);
            end
            pop_byte();
        end
        n_vec++;
        if (bus_if.kbd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drained ready got %b want 0", bus_if.kbd_ready);
        end
    endtask

    initial begin
        rst              = 1'b1;
        ps2_clk          = 1'b1;
        ps2_data         = 1'b1;
        bus_if.kbd_rd    = 1'b0;
        bus_if.kbd_we    = 1'b0;
        bus_if.kbd_wdata = '0;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_overflow();
        test_timeout();
        test_glitch();
        test_simultaneous();
        test_flush_and_bad_stop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_dev_io.md
Name: ps2_kbd_dev_io

Overview:
PS/2 keyboard receiver that exposes received scan codes on the MIO bus as a polled/interrupting input peripheral. It is the input counterpart to the display-side devices. It deserialises the 11-bit PS/2 device-to-host frame, checks start, parity and stop, and queues good bytes in a small FIFO. The CPU reads status and the head byte, and pops with a read strobe.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth 8)
FILTER_LEN, 8, consecutive equal samples required before the filtered ps2_clk changes
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock; all logic is on this single clock
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  asynchronous PS/2 clock from the keyboard
ps2_data  input  1  asynchronous PS/2 data from the keyboard
kbd_rd  input  1  single-cycle pop strobe from the bus decoder
kbd_we  input  1  single-cycle control write strobe
kbd_wdata  input  32  control word: [31]=flush FIFO, [30]/[29]/[28]=clear overflow/parity_err/frame_err
kbd_status_out  output  32  {valid, overflow, parity_err, frame_err, 4'b0, 4'b0 ∥ count, 8'b0, head_byte}
kbd_ready  output  1  FIFO non-empty; usable as an interrupt

Behaviour:
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clock resets to 1. It takes the synchronised value only after FILTER_LEN consecutive equal samples.
  - A 1→0 transition of the filtered clock is a sample event. On that event, the synchronised ps2_data is sampled.
- Receiver FSM states: IDLE, DATA, PARITY, STOP. Reset state is IDLE.
  - IDLE: on sample with data=0 → DATA, bitcnt=0. On sample with data=1 → stay IDLE and set frame_err.
  - DATA: shift right, new bit enters [7] (LSB first on the wire). After the 8th bit → PARITY.
  - PARITY: record parity_ok = XOR(8 data bits, parity bit) == 1 → STOP.
  - STOP: if stop=1 and parity_ok, push the byte. If stop=0, set frame_err. If parity is bad, set parity_err; both flags may set in the same cycle. Always → IDLE.
- Timeout:
  - The counter runs in every state except IDLE and clears on each sample event.
  - When it reaches TIMEOUT_CYCLES: → IDLE, set frame_err, discard the partial byte.
- FIFO: depth 2^FIFO_AW; count is FIFO_AW+1 bits, range 0..8.
  - Push when full: drop the new byte, set overflow.
  - Pop (kbd_rd) when empty: ignored, no flag.
  - Same-cycle push and pop, non-empty (including full): both happen, count unchanged, no overflow.
  - Same-cycle push and pop, empty: pop ignored, push happens.
  - Pointers wrap modulo depth.
- Flush: kbd_we with kbd_wdata[31]=1 empties the FIFO. A push in the same cycle is lost.
- Sticky flags: set by the events above; cleared by kbd_we with the corresponding wdata bit = 1. A set event in the same cycle wins over the clear.
- kbd_status_out is combinational from registered state:
  - bit31 = count≠0.
  - [19:16] = count, zero-extended.
  - [7:0] = FIFO head when non-empty, else 0x00.
  - Remaining bits are 0.
- kbd_ready = count≠0.
- Latency: a pushed byte is visible in status and kbd_ready the cycle after the STOP sample event. A pop is visible the next cycle.
- Reset, including mid-frame: FSM → IDLE, partial frame discarded, FIFO empty, all flags 0, filtered clock = 1, timeout counter 0. kbd_status_out = 0x0000_0000, kbd_ready = 0.

Test Plan:
(Bench uses FILTER_LEN=4, TIMEOUT_CYCLES=200, PS/2 bit period 40 clk.)
1. Good frame: send 0x1C with parity bit 0 and stop bit 1 → status = 0x8001_001C, kbd_ready=1. Pulse kbd_rd → status 0x0000_0000.
2. Bad parity: send 0x1C with parity bit 1 → no push, status = 0x2000_0000. kbd_we with wdata=0x2000_0000 → status 0.
3. Overflow: send 0x01..0x09 without reading → status = 0xC008_0001. Read 8 bytes → 0x01..0x08 in order, and the 9th pop is ignored.
4. Timeout: send start bit plus 3 data bits, then hold ps2_clk high for 200 clk → frame_err set (status 0x1000_0000). The following full frame 0xF0 → head 0xF0, count 1.
5. Glitch: a 2-cycle low pulse on ps2_clk → no sample event, FSM stays IDLE, status unchanged.
6. Simultaneous events:
   - FIFO holds 1 byte; pop coincides with the push of 0x5A → count stays 1, head 0x5A.
   - Assert rst mid-frame → status 0, and the next full frame is received correctly.
